// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, registered sync and video_on.
// Optional macro VGA_FRAME_CNT_EN adds the 8-bit frame_cnt output.
module vga_sync_gen #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   if (H_TOTAL > 1024) begin : g_h_total_chk
      $error("vga_sync_gen: H_TOTAL exceeds the 10-bit counter range");
   end
   if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_sync_gen: V_TOTAL exceeds the 10-bit counter range");
   end
   if (CLK_DIV < 2) begin : g_clk_div_chk
      $error("vga_sync_gen: CLK_DIV must be at least 2");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             hsync_q, vsync_q, video_on_q;
   logic             tick;

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   // Sync/video flags decode the next-state counters so they land on the same edge as pixel_x/pixel_y.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= '0;
         h_q        <= '0;
         v_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         h_q        <= h_d;
         v_q        <= v_d;
         hsync_q    <= !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
         vsync_q    <= !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
         video_on_q <= (h_d < H_VIS) && (v_d < V_VIS);
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else if (frame_start) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign p_tick      = tick;
   assign frame_start = tick && (h_q == '0) && (v_q == '0);
   assign pixel_x     = h_q;
   assign pixel_y     = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;

endmodule
